// File: rtl/fetch_bus_arbiter.sv
// Memory-bus arbiter for stage 0 fetch, load/store data and an external DMA master (Moore FSM).
// Optional DMA hold limit is enabled by defining DMA_HOLD_LIMIT_EN.
module fetch_bus_arbiter #(
    parameter int unsigned DMA_MAX_HOLD = 16
) (
    input  logic       ClockIn,
    input  logic       ResetIn_n,
    input  logic       DataReq,
    input  logic       DmaReq,
    output logic       DataGnt,
    output logic       DmaGnt,
    output logic       BusRequest,
    output logic       FetchSurpress,
    output logic [1:0] BusOwner
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StData    = 3'd1,
        StTurnIn  = 3'd2,
        StDma     = 3'd3,
        StTurnOut = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   dma_allowed;
    logic   dma_release;

`ifdef DMA_HOLD_LIMIT_EN
    localparam logic [7:0] MaxHoldCnt = 8'(DMA_MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       dma_block_q, dma_block_d;

    assign dma_allowed = ~dma_block_q;
    // Forced release happens on the DMA_MAX_HOLD-th consecutive DMA cycle.
    assign dma_release = ~DmaReq | (hold_cnt_q == MaxHoldCnt);

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        dma_block_d = dma_block_q;
        if (state_q == StTurnIn && state_d == StDma) begin
            hold_cnt_d = 8'd0;
        end else if (state_q == StDma) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
        if (state_q == StDma && DmaReq && hold_cnt_q == MaxHoldCnt) begin
            dma_block_d = 1'b1;
        end else if (state_q == StFetch || state_q == StData) begin
            dma_block_d = 1'b0;
        end
    end

    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            hold_cnt_q  <= 8'd0;
            dma_block_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            dma_block_q <= dma_block_d;
        end
    end
`else
    assign dma_allowed = 1'b1;
    assign dma_release = ~DmaReq;
`endif

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch: begin
                if (DataReq) begin
                    state_d = StData;
                end else if (DmaReq && dma_allowed) begin
                    state_d = StTurnIn;
                end else begin
                    state_d = StFetch;
                end
            end
            StData: begin
                if (DataReq) begin
                    state_d = StData;
                end else if (DmaReq && dma_allowed) begin
                    state_d = StTurnIn;
                end else begin
                    state_d = StFetch;
                end
            end
            StTurnIn:  state_d = DmaReq ? StDma : StFetch;
            StDma:     state_d = dma_release ? StTurnOut : StDma;
            StTurnOut: state_d = DataReq ? StData : StFetch;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend on the state register only; unreachable codes decode to all-zero.
    always_comb begin
        DataGnt       = 1'b0;
        DmaGnt        = 1'b0;
        BusRequest    = 1'b0;
        FetchSurpress = 1'b0;
        BusOwner      = 2'd0;
        unique case (state_q)
            StFetch: ;
            StData: begin
                DataGnt       = 1'b1;
                FetchSurpress = 1'b1;
                BusOwner      = 2'd1;
            end
            StTurnIn: begin
                BusRequest    = 1'b1;
                FetchSurpress = 1'b1;
                BusOwner      = 2'd3;
            end
            StDma: begin
                DmaGnt        = 1'b1;
                BusRequest    = 1'b1;
                FetchSurpress = 1'b1;
                BusOwner      = 2'd2;
            end
            StTurnOut: begin
                FetchSurpress = 1'b1;
                BusOwner      = 2'd3;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Self-checking bench for fetch_bus_arbiter: directed scenarios plus random traffic
// against a behavioural owner-phase model.
module tb_fetch_bus_arbiter;

    localparam int unsigned MaxHold = 4;

    logic       clk;
    logic       rst_n;
    logic       data_req;
    logic       dma_req;
    logic       data_gnt;
    logic       dma_gnt;
    logic       bus_request;
    logic       fetch_supp;
    logic [1:0] bus_owner;

    fetch_bus_arbiter #(
        .DMA_MAX_HOLD (MaxHold)
    ) dut (
        .ClockIn       (clk),
        .ResetIn_n     (rst_n),
        .DataReq       (data_req),
        .DmaReq        (dma_req),
        .DataGnt       (data_gnt),
        .DmaGnt        (dma_gnt),
        .BusRequest    (bus_request),
        .FetchSurpress (fetch_supp),
        .BusOwner      (bus_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model phases: who holds the bus this cycle.
    localparam int PFetch = 0;
    localparam int PData  = 1;
    localparam int PIn    = 2;
    localparam int PDma   = 3;
    localparam int POut   = 4;

    int n_assert;
    int n_fail;
    int phase;
    int dma_run;
    bit blocked;
    int br_cycles;
    int dg_cycles;

    // {DataGnt, DmaGnt, BusRequest, FetchSurpress, BusOwner}
    function automatic logic [5:0] expect_out(input int p);
        case (p)
            PData:   return 6'b1001_01;
            PIn:     return 6'b0011_11;
            PDma:    return 6'b0111_10;
            POut:    return 6'b0001_11;
            default: return 6'b0000_00;
        endcase
    endfunction

    function automatic logic [5:0] observed();
        return {data_gnt, dma_gnt, bus_request, fetch_supp, bus_owner};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase   = PFetch;
        dma_run = 0;
        blocked = 1'b0;
    endtask

    // Bus ownership for the next cycle from the requests seen at this edge.
    task automatic model_edge(input bit d, input bit q);
        bit dma_ok;
`ifdef DMA_HOLD_LIMIT_EN
        dma_ok = !blocked;
`else
        dma_ok = 1'b1;
`endif
        case (phase)
            PFetch, PData: begin
                phase = d ? PData : ((q && dma_ok) ? PIn : PFetch);
                blocked = 1'b0;
            end
            PIn: begin
                phase   = q ? PDma : PFetch;
                dma_run = 1;
            end
            PDma: begin
                if (!q) begin
                    phase = POut;
                end else begin
`ifdef DMA_HOLD_LIMIT_EN
                    if (dma_run >= int'(MaxHold)) begin
                        phase   = POut;
                        blocked = 1'b1;
                    end else begin
                        dma_run++;
                    end
`else
                    dma_run++;
`endif
                end
            end
            default: phase = d ? PData : PFetch;
        endcase
    endtask

    // One clock: drive at negedge, advance model at posedge, check 1 time unit later.
    task automatic step(input string tag, input bit d, input bit q);
        @(negedge clk);
        data_req = d;
        dma_req  = q;
        @(posedge clk);
        model_edge(d, q);
        #1;
        check(tag, 8'(observed()), 8'(expect_out(phase)));
        check({tag, "_excl"}, 8'(!(data_gnt && dma_gnt) && (!dma_gnt || bus_request)), 8'd1);
        if (bus_request) br_cycles++;
        if (dma_gnt) dg_cycles++;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_reset();
        rst_n    = 1'b0;
        data_req = 1'b1;
        dma_req  = 1'b1;

        // Reset held with both requests high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 8'(observed()), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("reset_exit", 1'b1, 1'b1);
        check("reset_exit_owner", 8'(bus_owner), 8'd1);
        step("reset_drain", 1'b0, 1'b0);
        step("reset_drain", 1'b0, 1'b0);
        step("reset_drain", 1'b0, 1'b0);
        step("reset_drain", 1'b0, 1'b0);

        // Single data access.
        step("single_data", 1'b1, 1'b0);
        step("single_data_end", 1'b0, 1'b0);
        check("single_data_idle", 8'(bus_owner), 8'd0);

        // DMA episode: request high for five cycles.
        br_cycles = 0;
        dg_cycles = 0;
        for (int i = 0; i < 5; i++) step("dma_episode", 1'b0, 1'b1);
        step("dma_episode", 1'b0, 1'b0);
        step("dma_episode", 1'b0, 1'b0);
        check("dma_busreq_cycles", 8'(br_cycles), 8'd5);
        check("dma_gnt_cycles", 8'(dg_cycles), 8'd4);

        // Collision: data wins, DMA follows.
        step("collide", 1'b1, 1'b1);
        check("collide_data", 8'(data_gnt), 8'd1);
        step("collide", 1'b1, 1'b1);
        step("collide", 1'b0, 1'b1);
        check("collide_turnin", 8'(bus_owner), 8'd3);
        step("collide", 1'b0, 1'b1);
        check("collide_dma", 8'(dma_gnt), 8'd1);

        // Reset asserted halfway through a DMA cycle.
        #4;
        rst_n = 1'b0;
        #1;
        check("reset_mid_dma", 8'({dma_gnt, bus_request, data_gnt}), 8'd0);
        model_reset();
        @(negedge clk);
        dma_req  = 1'b0;
        data_req = 1'b0;
        rst_n    = 1'b1;
        step("post_reset", 1'b0, 1'b0);

        // Long DMA hold; with the hold limit enabled the model expects forced releases.
        for (int i = 0; i < 20; i++) step("dma_long", 1'b0, 1'b1);
        step("dma_long_end", 1'b0, 1'b0);
        step("dma_long_end", 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 55));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/fetch_bus_arbiter.md
# fetch_bus_arbiter

Arbitrates the single memory bus between pipeline stage 0 instruction fetch, the later-stage load/store port, and an external DMA master. Sits beside stage 0 and drives its `BusRequest` and `FetchSurpress` inputs, so stage 0 never has to know who owns the bus. Built as a Moore state machine with explicit one-cycle bus turnarounds around DMA ownership.

## Interface
- `DMA_MAX_HOLD`, default 16: maximum consecutive `S_DMA` cycles before a forced release. Legal range 2..255. Used only with `DMA_HOLD_LIMIT_EN`.
- `ClockIn`  in  1  system clock; all state changes on the rising edge.
- `ResetIn_n`  in  1  asynchronous, active-low reset.
- `DataReq`  in  1  load/store stage requests the bus; held high until it sees `DataGnt`.
- `DmaReq`  in  1  external master requests the bus; level, held for the whole transfer.
- `DataGnt`  out  1  bus granted to the load/store stage this cycle.
- `DmaGnt`  out  1  bus granted to the DMA master this cycle.
- `BusRequest`  out  1  to stage 0: the bus is taken by DMA or by a turnaround.
- `FetchSurpress`  out  1  to stage 0: no fetch this cycle; the PC must not advance.
- `BusOwner`  out  2  0 = fetch, 1 = data, 2 = DMA, 3 = turnaround.

## Operation
- The state register is 3 bits. Every output decodes from the state register only, with no input-to-output combinational path.
- **S_FETCH**: all outputs 0 and `BusOwner`=0.
  - `DataReq` → S_DATA.
  - Otherwise `DmaReq` → S_TURN_IN.
  - Otherwise stay.
- **S_DATA**: `DataGnt`=1, `FetchSurpress`=1, `BusOwner`=1.
  - `DataReq` still high → stay (back-to-back data cycles).
  - Otherwise `DmaReq` → S_TURN_IN.
  - Otherwise → S_FETCH.
- **S_TURN_IN**: `BusRequest`=1, `FetchSurpress`=1, `BusOwner`=3.
  - `DmaReq` still high → S_DMA.
  - `DmaReq` withdrawn → S_FETCH.
- **S_DMA**: `DmaGnt`=1, `BusRequest`=1, `FetchSurpress`=1, `BusOwner`=2.
  - Stay while `DmaReq` is high.
  - `DmaReq` low → S_TURN_OUT.
- **S_TURN_OUT**: `BusRequest`=0, `FetchSurpress`=1, `BusOwner`=3.
  - `DataReq` → S_DATA.
  - Otherwise → S_FETCH. S_TURN_OUT never goes directly to S_TURN_IN.
- Priority at every arbitration point: data > DMA > fetch.
- `DataReq` during S_TURN_IN or S_DMA is not granted. The load/store stage stalls until S_TURN_OUT completes.
- `DmaGnt` and `DataGnt` are never high together. `DmaGnt`=1 always implies `BusRequest`=1.
- Encodings 5–7 are unreachable. If entered, they must return to S_FETCH on the next edge with all outputs 0.

## Timing
- Reset: while `ResetIn_n`=0, the block is in S_FETCH with every output 0, independent of `ClockIn`. It leaves reset on the first rising edge after `ResetIn_n` is deasserted.
- Reset asserted mid-DMA or mid-data: `DmaGnt` and `DataGnt` drop immediately (asynchronously). No turnaround cycle is produced.
- Data latency: `DataReq` sampled high at edge N gives `DataGnt` from edge N to edge N+1.
- DMA latency: `DmaReq` sampled at edge N gives S_TURN_IN at N, then `DmaGnt` from edge N+1.
- DMA release: `DmaReq` sampled low at edge M gives `DmaGnt` low at M, S_TURN_OUT for one cycle, then fetch or data from M+1.
- `DataReq` and `DmaReq` rising together from S_FETCH: data wins and DMA follows once `DataReq` drops.
- Minimum DMA episode is 3 cycles with `FetchSurpress`=1: turn-in, one DMA cycle, turn-out.

## Configuration
- `DMA_HOLD_LIMIT_EN` defined:
  - An 8-bit hold counter clears on entry to S_DMA and increments each S_DMA cycle.
  - When the counter reaches `DMA_MAX_HOLD`, the block goes to S_TURN_OUT even if `DmaReq` is high.
  - A sticky `dma_block` bit then forbids S_TURN_IN until at least one S_FETCH or S_DATA cycle has completed. The bit clears on that cycle.
  - Reset clears both the counter and `dma_block`.
- `DMA_HOLD_LIMIT_EN` undefined: DMA holds the bus for as long as `DmaReq` is high. No counter or `dma_block` logic is synthesised, and `DMA_MAX_HOLD` is ignored.

## Test plan
- **Reset**: hold `ResetIn_n`=0 for 3 cycles with `DmaReq`=`DataReq`=1 → all outputs 0 and `BusOwner`=0. After release, the first edge gives `DataGnt`=1 and `BusOwner`=1.
- **Single data access**: pulse `DataReq` for 1 cycle from idle → `DataGnt`=1 and `FetchSurpress`=1 for exactly 1 cycle, then `BusOwner`=0.
- **DMA episode**: raise `DmaReq` for 5 cycles → `BusOwner` sequence 3,2,2,2,2,3,0. `BusRequest`=1 for exactly 5 cycles and `DmaGnt`=1 for exactly 4 cycles.
- **Collision**: raise `DataReq` and `DmaReq` on the same edge, with `DataReq` held for 2 cycles → `DataGnt` for 2 cycles, then turn-in, then `DmaGnt`.
- **Reset mid-DMA**: assert `ResetIn_n`=0 halfway through the S_DMA cycle → `DmaGnt` and `BusRequest` go to 0 before the next rising edge.
- **Hold limit** (`DMA_HOLD_LIMIT_EN`, `DMA_MAX_HOLD`=4): hold `DmaReq` high for 20 cycles → repeating pattern of 4 `DmaGnt` cycles, turn-out, ≥1 fetch cycle, turn-in. No checked cycle has both grants high.
